// File: rtl/pulp_cluster_package.sv
// Cluster-wide constants shared by the SoC event path.
package pulp_cluster_package;

    localparam int unsigned SOC_EVT_FIFO_DEPTH = 8;
    localparam int unsigned SOC_EVT_DROP_CNT_W = 16;
    localparam int unsigned SOC_EVT_WIDTH      = 8;

    // Pointer width for a power-of-two ring that keeps one extra wrap bit.
    function automatic int unsigned soc_evt_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cluster_soc_evt_fifo.sv
// First-word fall-through buffer between the SoC event input and the event unit,
// optionally dropping (and counting) events that arrive while it is full.
module cluster_soc_evt_fifo
    import pulp_cluster_package::*;
#(
    parameter int unsigned EVNT_WIDTH   = SOC_EVT_WIDTH,
    parameter int unsigned DEPTH        = SOC_EVT_FIFO_DEPTH,
    parameter bit          DROP_ON_FULL = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       cnt_clear_i,
    input  logic                       src_valid_i,
    input  logic [EVNT_WIDTH-1:0]      src_data_i,
    output logic                       src_ready_o,
    output logic                       evt_valid_o,
    output logic [EVNT_WIDTH-1:0]      evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [SOC_EVT_DROP_CNT_W-1:0] drop_cnt_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = soc_evt_ptr_width(DEPTH);
    localparam int unsigned CW = SOC_EVT_DROP_CNT_W;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [EVNT_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // Wrap bits differ with equal indices means the writer lapped the reader.
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign src_ready_o = DROP_ON_FULL ? 1'b1 : !full;
    assign evt_valid_o = !empty;
    assign evt_data_o  = mem[rd_ptr_q[AW-1:0]];
    assign level_o     = wr_ptr_q - rd_ptr_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = overflow_q;

    // A flush swallows the offered event without treating it as a drop.
    assign push = src_valid_i && src_ready_o && !full && !flush_i;
    assign pop  = evt_valid_o && evt_ready_i && !flush_i;
    assign drop = DROP_ON_FULL && src_valid_i && full && !flush_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = drop;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        if (cnt_clear_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; stale entries are never visible once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= src_data_i;
        end
    end

endmodule

// File: tb/tb_cluster_soc_evt_fifo.sv
// Drives a dropping and a backpressuring instance with shared stimulus and
// compares both against queue-based reference models.
module tb_cluster_soc_evt_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rstN;
    logic flush;
    logic cntClear;
    logic srcValid;
    logic [W-1:0] srcData;
    logic evtReady;

    logic [1:0]          srcReady;
    logic [1:0]          evtValid;
    logic [1:0]          overflow;
    logic [1:0][W-1:0]   evtData;
    logic [1:0][LW-1:0]  level;
    logic [1:0][15:0]    dropCnt;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int mDrop [2];
    bit mOvf  [2];

    always #5 clk = ~clk;

    // Index 0 backpressures the source, index 1 discards on full.
    cluster_soc_evt_fifo #(.EVNT_WIDTH(W), .DEPTH(D), .DROP_ON_FULL(1'b0)) dutBp (
        .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .cnt_clear_i(cntClear),
        .src_valid_i(srcValid), .src_data_i(srcData), .src_ready_o(srcReady[0]),
        .evt_valid_o(evtValid[0]), .evt_data_o(evtData[0]), .evt_ready_i(evtReady),
        .level_o(level[0]), .drop_cnt_o(dropCnt[0]), .overflow_o(overflow[0])
    );

    cluster_soc_evt_fifo #(.EVNT_WIDTH(W), .DEPTH(D), .DROP_ON_FULL(1'b1)) dutDrop (
        .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .cnt_clear_i(cntClear),
        .src_valid_i(srcValid), .src_data_i(srcData), .src_ready_o(srcReady[1]),
        .evt_valid_o(evtValid[1]), .evt_data_o(evtData[1]), .evt_ready_i(evtReady),
        .level_o(level[1]), .drop_cnt_o(dropCnt[1]), .overflow_o(overflow[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Compare every output of both instances with the model's view.
    task automatic checkAll();
        for (int d = 0; d < 2; d++) begin
            logic [W-1:0] q[$];
            if (d == 1) q = q1; else q = q0;
            checkOutput($sformatf("m%0d evt_valid", d), 32'(evtValid[d]), 32'(q.size() != 0));
            if (q.size() != 0)
                checkOutput($sformatf("m%0d evt_data", d), 32'(evtData[d]), 32'(q[0]));
            checkOutput($sformatf("m%0d level", d), 32'(level[d]), 32'(q.size()));
            checkOutput($sformatf("m%0d src_ready", d), 32'(srcReady[d]),
                        (d == 1) ? 32'd1 : 32'(q.size() != D));
            checkOutput($sformatf("m%0d drop_cnt", d), 32'(dropCnt[d]), 32'(mDrop[d]));
            checkOutput($sformatf("m%0d overflow", d), 32'(overflow[d]), 32'(mOvf[d]));
        end
    endtask

    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            logic [W-1:0] q[$];
            bit isFull;
            bit isDrop;
            if (d == 1) q = q1; else q = q0;
            isFull = (q.size() == D);
            isDrop = (d == 1) && srcValid && isFull && !flush;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && evtReady) void'(q.pop_front());
                if (srcValid && !isFull) q.push_back(srcData);
            end
            mOvf[d] = isDrop;
            if (cntClear) mDrop[d] = 0;
            else if (isDrop && mDrop[d] < 65535) mDrop[d]++;
            if (d == 1) q1 = q; else q0 = q;
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            mDrop[d] = 0;
            mOvf[d]  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [W-1:0] data, input bit rdy,
                                 input bit fl, input bit clr);
        srcValid = v;
        srcData  = data;
        evtReady = rdy;
        flush    = fl;
        cntClear = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        int ovfSeen;
        rstN = 1'b0;
        flush = 0; cntClear = 0; srcValid = 0; srcData = '0; evtReady = 0;
        modelReset();
        #2;
        checkAll();
        checkOutput("reset src_ready bp", 32'(srcReady[0]), 32'd1);
        #10 rstN = 1'b1;

        // Single event into an empty FIFO
        applyStimulus(1, 8'h2A, 0, 0, 0);
        checkOutput("single valid", 32'(evtValid[1]), 32'd1);
        checkOutput("single data", 32'(evtData[1]), 32'h2A);
        checkOutput("single level", 32'(level[1]), 32'd1);

        // Overfill with the sink stalled, then drain
        applyStimulus(0, 0, 0, 1, 1);
        ovfSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, W'(i), 0, 0, 0);
            ovfSeen += int'(overflow[1]);
        end
        applyStimulus(0, 0, 0, 0, 0);
        ovfSeen += int'(overflow[1]);
        checkOutput("fill level", 32'(level[1]), 32'd8);
        checkOutput("fill ovf pulses", 32'(ovfSeen), 32'd2);
        checkOutput("fill drop_cnt", 32'(dropCnt[1]), 32'd2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain order", 32'(evtData[1]), 32'(i));
            applyStimulus(0, 0, 1, 0, 0);
        end
        checkOutput("drain empty", 32'(evtValid[1]), 32'd0);

        // Backpressure instance: full stalls, one pop reopens
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, W'(8'h40 + i), 0, 0, 0);
        checkOutput("bp ready full", 32'(srcReady[0]), 32'd0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("bp ready after pop", 32'(srcReady[0]), 32'd1);
        applyStimulus(1, 8'h99, 0, 0, 0);
        checkOutput("bp ninth level", 32'(level[0]), 32'd8);
        checkOutput("bp drop_cnt", 32'(dropCnt[0]), 32'd0);

        // Full-rate stream through the pointer wrap
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, W'(i), 1, 0, 0);
            checkOutput("stream level", 32'(level[1]), 32'd1);
        end
        applyStimulus(0, 0, 1, 0, 0);

        // Flush with a simultaneous push, then clear during an overflow
        for (int i = 0; i < 5; i++) applyStimulus(1, W'(8'h70 + i), 0, 0, 0);
        ovfSeen = int'(dropCnt[1]);
        applyStimulus(1, 8'hEE, 0, 1, 0);
        checkOutput("flush level", 32'(level[1]), 32'd0);
        checkOutput("flush valid", 32'(evtValid[1]), 32'd0);
        checkOutput("flush no drop", 32'(dropCnt[1]), 32'(ovfSeen));
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, W'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'hD0, 0, 0, 0);
        checkOutput("three drops", 32'(dropCnt[1]), 32'd3);
        applyStimulus(1, 8'hD1, 0, 0, 1);
        checkOutput("clear wins", 32'(dropCnt[1]), 32'd0);
        checkOutput("clear ovf pulse", 32'(overflow[1]), 32'd1);

        // Drop counter saturation
        for (int i = 0; i < 65538; i++) applyStimulus(1, 8'hF0, 0, 0, 0);
        checkOutput("drop saturate", 32'(dropCnt[1]), 32'hFFFF);

        // Randomized traffic with varying sink throughput
        for (int p = 0; p < 15; p++) begin
            int rp;
            case (p % 3)
                0:       rp = 10;
                1:       rp = 50;
                default: rp = 90;
            endcase
            for (int i = 0; i < 200; i++)
                applyStimulus($urandom_range(99) < 70, W'($urandom), $urandom_range(99) < rp,
                              $urandom_range(99) < 2, $urandom_range(99) < 2);
        end

        // Asynchronous reset in the middle of a cycle
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, W'(8'hA0 + i), 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #3 rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("async valid", 32'(evtValid[1]), 32'd0);
        checkOutput("async level", 32'(level[1]), 32'd0);
        #2 rstN = 1'b1;
        applyStimulus(1, 8'h5C, 0, 0, 0);
        checkOutput("post reset data", 32'(evtData[1]), 32'h5C);
        applyStimulus(0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
